// File: rtl/uart_tx_buffer_pkg.sv
// Shared constants and FSM encoding for the UART transmit buffer.
// State encodings keep the legacy TXB_IDLE = 0 / TXB_WAIT = 1 values.
package uart_tx_buffer_pkg;

  localparam int unsigned TXB_DEPTH  = 16;
  localparam int unsigned TXB_ADDR_W = 4;

  typedef enum logic [0:0] {
    TXB_IDLE = 1'b0,
    TXB_WAIT = 1'b1
  } txb_state_t;

endpackage

// File: rtl/tx_byte_fifo.sv
// Circular byte FIFO with synchronous flush and a sticky overflow flag.
// Memory contents are intentionally not reset.
module tx_byte_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = TXB_DEPTH,
  parameter int unsigned ADDR_W = TXB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  // Acceptance is judged on the registered level, so a same-edge pop
  // never frees room for a push into a full FIFO.
  assign wr_ready = (level != FULL);
  assign push     = wr_en && wr_ready && !flush;
  assign pop      = rd_en && (level != '0) && !flush;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && !wr_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Drain sequencer: launches one queued byte into uart_tx per tx_done,
// with registered tx_data/tx_start outputs.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = TXB_DEPTH,
  parameter int unsigned ADDR_W = TXB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [ADDR_W:0]   level,
  output logic              busy,
  output logic              overflow
);

  txb_state_t  state;
  txb_state_t  state_nxt;
  logic        launch;
  logic [7:0]  rd_data;

  tx_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_en    (launch),
    .rd_data  (rd_data),
    .level    (level),
    .overflow (overflow)
  );

  // Flush suppresses launch but leaves an in-flight byte to finish.
  always_comb begin
    launch    = 1'b0;
    state_nxt = state;
    case (state)
      TXB_IDLE: begin
        if (level != '0 && !flush) begin
          launch    = 1'b1;
          state_nxt = TXB_WAIT;
        end
      end
      TXB_WAIT: begin
        if (tx_done) begin
          if (level != '0 && !flush) launch = 1'b1;
          else                       state_nxt = TXB_IDLE;
        end
      end
      default: state_nxt = TXB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TXB_IDLE;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_start <= launch;
      if (launch) tx_data <= rd_data;
    end
  end

  assign busy = (state != TXB_IDLE) || (level != '0);

endmodule
